// File: rtl/tinyqv_sram_mem_ctrl_pkg.sv
// rtl/tinyqv_sram_mem_ctrl_pkg.sv - access size codes and lane helpers for the SRAM memory controller
package tinyqv_sram_mem_ctrl_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_IDLE = 2'b11;

  // Byte stores land in the lane selected by the byte-address LSB.
  function automatic logic [1:0] byte_lane_be(input logic b0);
    return b0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tinyqv_sram_mem_ctrl.sv
// rtl/tinyqv_sram_mem_ctrl.sv - instruction-stream and data-access responder over a 16-bit synchronous SRAM
module tinyqv_sram_mem_ctrl
  import tinyqv_sram_mem_ctrl_pkg::*;
#(
  parameter int SRAM_AW = 15
) (
  input  logic               clk,
  input  logic               rst,

  input  logic [23:1]        instr_addr,
  input  logic               instr_fetch_restart,
  input  logic               instr_fetch_stall,
  output logic               instr_fetch_started,
  output logic               instr_fetch_stopped,
  output logic [15:0]        instr_data_in,
  output logic               instr_ready,

  input  logic [27:0]        data_addr,
  input  logic [1:0]         data_write_n,
  input  logic [1:0]         data_read_n,
  input  logic               data_read_complete,
  input  logic [31:0]        data_out,
  input  logic               data_continue,
  output logic               data_ready,
  output logic [31:0]        data_in,

  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_en,
  output logic               sram_we,
  output logic [1:0]         sram_be,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IFETCH,
    S_DACC,
    S_DACC2,
    S_DRESP,
    S_DDONE
  } state_t;

  state_t             state_q, state_d;
  logic [SRAM_AW-1:0] fetch_ptr_q, fetch_ptr_d;
  logic               ifetch_rd_q, ifetch_rd_d;

  logic               acc_write_q;
  logic [1:0]         acc_size_q;
  logic [SRAM_AW-1:0] acc_addr_q;
  logic               acc_b0_q;
  logic [31:0]        acc_wdata_q;

  logic [15:0]        rd_lo_q;
  logic               rd_done_q;
  logic [31:0]        data_in_q;

  logic               req_idle;
  logic               data_req;
  logic               accept;
  logic               wr_done;
  logic [SRAM_AW-1:0] acc_hi_addr;
  logic [SRAM_AW-1:0] fetch_next;

  logic               unused_inputs;
  assign unused_inputs = ^{data_read_complete, data_continue,
                           data_addr[23:SRAM_AW+1], instr_addr[23:SRAM_AW+1]};

  assign req_idle    = (data_read_n == MEM_IDLE) && (data_write_n == MEM_IDLE);
  assign data_req    = !req_idle && (data_addr[27:24] == 4'h0);
  assign acc_hi_addr = acc_addr_q + SRAM_AW'(1);
  assign fetch_next  = fetch_ptr_q + SRAM_AW'(1);

  always_comb begin
    state_d             = state_q;
    fetch_ptr_d         = fetch_ptr_q;
    ifetch_rd_d         = 1'b0;
    accept              = 1'b0;
    wr_done             = 1'b0;
    sram_en             = 1'b0;
    sram_we             = 1'b0;
    sram_be             = 2'b11;
    sram_addr           = '0;
    sram_wdata          = 16'h0;
    instr_fetch_started = 1'b0;
    instr_fetch_stopped = 1'b0;

    if (!rst) begin
      case (state_q)
        S_IDLE, S_IFETCH: begin
          if (data_req) begin
            accept              = 1'b1;
            instr_fetch_stopped = (state_q == S_IFETCH);
            state_d             = S_DACC;
          end else if (instr_fetch_restart) begin
            sram_en             = 1'b1;
            sram_addr           = instr_addr[SRAM_AW:1];
            fetch_ptr_d         = instr_addr[SRAM_AW:1];
            ifetch_rd_d         = 1'b1;
            instr_fetch_started = 1'b1;
            state_d             = S_IFETCH;
          end else if (state_q == S_IFETCH && !instr_fetch_stall) begin
            sram_en     = 1'b1;
            sram_addr   = fetch_next;
            fetch_ptr_d = fetch_next;
            ifetch_rd_d = 1'b1;
          end
        end

        S_DACC: begin
          sram_en   = 1'b1;
          sram_we   = acc_write_q;
          sram_addr = acc_addr_q;
          if (acc_write_q) begin
            if (acc_size_q == MEM_BYTE) begin
              sram_be    = byte_lane_be(acc_b0_q);
              sram_wdata = {2{acc_wdata_q[7:0]}};
            end else begin
              sram_wdata = acc_wdata_q[15:0];
            end
          end
          if (acc_size_q == MEM_WORD) begin
            state_d = S_DACC2;
          end else if (acc_write_q) begin
            wr_done = 1'b1;
            state_d = S_DDONE;
          end else begin
            state_d = S_DRESP;
          end
        end

        S_DACC2: begin
          sram_en   = 1'b1;
          sram_we   = acc_write_q;
          sram_addr = acc_hi_addr;
          if (acc_write_q) begin
            sram_wdata = acc_wdata_q[31:16];
            wr_done    = 1'b1;
            state_d    = S_DDONE;
          end else begin
            state_d = S_DRESP;
          end
        end

        S_DRESP: state_d = S_DDONE;

        // A request still held after completion must not be re-issued.
        S_DDONE: if (req_idle) state_d = S_IDLE;

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_ptr_q <= '0;
      ifetch_rd_q <= 1'b0;
      acc_write_q <= 1'b0;
      acc_size_q  <= MEM_IDLE;
      acc_addr_q  <= '0;
      acc_b0_q    <= 1'b0;
      acc_wdata_q <= 32'h0;
      rd_lo_q     <= 16'h0;
      rd_done_q   <= 1'b0;
      data_in_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      ifetch_rd_q <= ifetch_rd_d;
      rd_done_q   <= (state_q == S_DRESP);

      if (accept) begin
        acc_write_q <= (data_write_n != MEM_IDLE);
        acc_size_q  <= (data_write_n != MEM_IDLE) ? data_write_n : data_read_n;
        acc_addr_q  <= data_addr[SRAM_AW:1];
        acc_b0_q    <= data_addr[0];
        acc_wdata_q <= data_out;
      end

      // The low half of a word read arrives while the high half is being read.
      if (state_q == S_DACC2 && !acc_write_q) rd_lo_q <= sram_rdata;

      if (state_q == S_DRESP) begin
        case (acc_size_q)
          MEM_BYTE: data_in_q <= {24'h0, acc_b0_q ? sram_rdata[15:8] : sram_rdata[7:0]};
          MEM_HALF: data_in_q <= {16'h0, sram_rdata};
          default:  data_in_q <= {sram_rdata, rd_lo_q};
        endcase
      end
    end
  end

  assign instr_ready   = ifetch_rd_q;
  assign instr_data_in = ifetch_rd_q ? sram_rdata : 16'h0;
  assign data_ready    = wr_done | rd_done_q;
  assign data_in       = data_in_q;

endmodule

// File: tb/tb_tinyqv_sram_mem_ctrl.sv
// tb/tb_tinyqv_sram_mem_ctrl.sv - directed self-checking bench for the SRAM memory controller
module tb_tinyqv_sram_mem_ctrl;
  import tinyqv_sram_mem_ctrl_pkg::*;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [23:1]   instr_addr;
  logic          instr_fetch_restart;
  logic          instr_fetch_stall;
  logic          instr_fetch_started;
  logic          instr_fetch_stopped;
  logic [15:0]   instr_data_in;
  logic          instr_ready;
  logic [27:0]   data_addr;
  logic [1:0]    data_write_n;
  logic [1:0]    data_read_n;
  logic          data_read_complete;
  logic [31:0]   data_out;
  logic          data_continue;
  logic          data_ready;
  logic [31:0]   data_in;
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_we;
  logic [1:0]    sram_be;
  logic [15:0]   sram_wdata;
  logic [15:0]   sram_rdata;

  logic [15:0]   mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [15:0]   pre_data;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  tinyqv_sram_mem_ctrl #(.SRAM_AW(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instr_addr          (instr_addr),
    .instr_fetch_restart (instr_fetch_restart),
    .instr_fetch_stall   (instr_fetch_stall),
    .instr_fetch_started (instr_fetch_started),
    .instr_fetch_stopped (instr_fetch_stopped),
    .instr_data_in       (instr_data_in),
    .instr_ready         (instr_ready),
    .data_addr           (data_addr),
    .data_write_n        (data_write_n),
    .data_read_n         (data_read_n),
    .data_read_complete  (data_read_complete),
    .data_out            (data_out),
    .data_continue       (data_continue),
    .data_ready          (data_ready),
    .data_in             (data_in),
    .sram_addr           (sram_addr),
    .sram_en             (sram_en),
    .sram_we             (sram_we),
    .sram_be             (sram_be),
    .sram_wdata          (sram_wdata),
    .sram_rdata          (sram_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (sram_en) begin
      if (sram_we) begin
        if (sram_be[0]) mem[sram_addr][7:0]  <= sram_wdata[7:0];
        if (sram_be[1]) mem[sram_addr][15:8] <= sram_wdata[15:8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_ready, instr_fetch_started, instr_fetch_stopped, data_ready, sram_en, sram_we} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000",
               {instr_ready, instr_fetch_started, instr_fetch_stopped, data_ready, sram_en, sram_we});
    else passes++;
    checks++;
    if (instr_data_in !== 16'h0) $display("FAIL reset_instr_data: got %h want 0000", instr_data_in);
    else passes++;
    checks++;
    if (data_in !== 32'h0) $display("FAIL reset_data_in: got %h want 00000000", data_in);
    else passes++;
    tick();
  endtask

  task automatic test_fetch_stall();
    logic [15:0] got [16];
    logic [15:0] exp_hw;
    int k, idle;
    for (int i = 0; i < 12; i++) preload(AW'(16'h100 + i), 16'hA000 + 16'(i) * 16'h0111);
    instr_addr = 23'h100;
    instr_fetch_restart = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_fetch_started !== 1'b1) $display("FAIL fetch_started: got %b want 1", instr_fetch_started);
    else passes++;
    checks++;
    if ({sram_en, sram_we, sram_addr} !== {1'b1, 1'b0, 15'h100})
      $display("FAIL fetch_first_read: got en=%b we=%b addr=%h want en=1 we=0 addr=0100", sram_en, sram_we, sram_addr);
    else passes++;
    tick();
    instr_fetch_restart = 1'b0;
    k = 0; idle = 0;
    for (int c = 0; c < 12; c++) begin
      instr_fetch_stall = (c == 4 || c == 5);
      @(negedge clk);
      if (instr_ready === 1'b1) begin
        if (k < 16) got[k] = instr_data_in;
        k++;
      end else idle++;
      if (c == 4 || c == 5) begin
        checks++;
        if (sram_en !== 1'b0) $display("FAIL stall_no_read c=%0d: got sram_en=%b want 0", c, sram_en);
        else passes++;
      end
      tick();
    end
    instr_fetch_stall = 1'b0;
    checks++;
    if (k !== 10) $display("FAIL fetch_count: got %0d want 10", k);
    else passes++;
    checks++;
    if (idle !== 2) $display("FAIL stall_gap: got %0d idle cycles want 2", idle);
    else passes++;
    for (int j = 0; j < 10; j++) begin
      exp_hw = 16'hA000 + 16'(j) * 16'h0111;
      checks++;
      if (j >= k || got[j] !== exp_hw) $display("FAIL fetch_data[%0d]: got %h want %h", j, got[j], exp_hw);
      else passes++;
    end
  endtask

  task automatic test_preempt_read();
    int lat;
    logic saw_instr;
    preload(15'h100, 16'hBABE);
    preload(15'h101, 16'hCAFE);
    data_addr = 28'h200;
    data_read_n = MEM_WORD;
    @(negedge clk);
    checks++;
    if (instr_fetch_stopped !== 1'b1) $display("FAIL preempt_stopped: got %b want 1", instr_fetch_stopped);
    else passes++;
    checks++;
    if (instr_ready !== 1'b1) $display("FAIL preempt_last_instr: got %b want 1", instr_ready);
    else passes++;
    checks++;
    if (sram_en !== 1'b0) $display("FAIL preempt_no_fetch: got sram_en=%b want 0", sram_en);
    else passes++;
    tick();
    lat = 0; saw_instr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (instr_ready === 1'b1) saw_instr = 1'b1;
      if (k == 1) begin
        checks++;
        if ({sram_en, sram_we, sram_addr} !== {1'b1, 1'b0, 15'h100})
          $display("FAIL word_read_lo: got en=%b we=%b addr=%h want en=1 we=0 addr=0100", sram_en, sram_we, sram_addr);
        else passes++;
      end
      if (k == 2) begin
        checks++;
        if ({sram_en, sram_we, sram_addr} !== {1'b1, 1'b0, 15'h101})
          $display("FAIL word_read_hi: got en=%b we=%b addr=%h want en=1 we=0 addr=0101", sram_en, sram_we, sram_addr);
        else passes++;
      end
      if (data_ready === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    checks++;
    if (lat !== 4) $display("FAIL word_read_latency: got %0d want 4 (0 = timeout)", lat);
    else passes++;
    checks++;
    if (data_in !== 32'hCAFEBABE) $display("FAIL word_read_data: got %h want cafebabe", data_in);
    else passes++;
    checks++;
    if (saw_instr !== 1'b0) $display("FAIL no_stream_during_access: got instr_ready seen=%b want 0", saw_instr);
    else passes++;
    tick();
    data_read_n = MEM_IDLE;
    instr_addr = 23'h100;
    instr_fetch_restart = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_fetch_started !== 1'b0) $display("FAIL restart_held_in_ddone: got %b want 0", instr_fetch_started);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (instr_fetch_started !== 1'b1) $display("FAIL restart_after_ddone: got %b want 1", instr_fetch_started);
    else passes++;
    tick();
    instr_fetch_restart = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_ready, instr_data_in} !== {1'b1, 16'hBABE})
      $display("FAIL restart_data: got ready=%b data=%h want ready=1 data=babe", instr_ready, instr_data_in);
    else passes++;
    tick();
  endtask

  task automatic test_ignored_region();
    logic bad;
    bad = 1'b0;
    data_addr = 28'h1000200;
    data_read_n = MEM_HALF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (instr_fetch_stopped !== 1'b0 || data_ready !== 1'b0 || instr_ready !== 1'b1) bad = 1'b1;
      tick();
    end
    data_read_n = MEM_IDLE;
    checks++;
    if (bad !== 1'b0) $display("FAIL ignored_region: got disturbance=%b want 0", bad);
    else passes++;
  endtask

  task automatic test_byte_write_half_read();
    int lat;
    logic bad;
    preload(15'h180, 16'h1234);
    data_addr = 28'h301;
    data_out = 32'hFFFF_FF5A;
    data_write_n = MEM_BYTE;
    @(negedge clk);
    checks++;
    if (instr_fetch_stopped !== 1'b1) $display("FAIL write_preempt_stopped: got %b want 1", instr_fetch_stopped);
    else passes++;
    tick();
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (data_ready === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    checks++;
    if (lat !== 1) $display("FAIL byte_write_latency: got %0d want 1 (0 = timeout)", lat);
    else passes++;
    checks++;
    if ({sram_en, sram_we, sram_be, sram_addr, sram_wdata} !== {1'b1, 1'b1, 2'b10, 15'h180, 16'h5A5A})
      $display("FAIL byte_write_strobe: got en=%b we=%b be=%b addr=%h wdata=%h want en=1 we=1 be=10 addr=0180 wdata=5a5a",
               sram_en, sram_we, sram_be, sram_addr, sram_wdata);
    else passes++;
    tick();
    bad = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (data_ready !== 1'b0 || sram_en !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) $display("FAIL held_write_reissued: got reissue=%b want 0", bad);
    else passes++;
    data_write_n = MEM_IDLE;
    tick();
    data_addr = 28'h300;
    data_read_n = MEM_HALF;
    tick();
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (data_ready === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    checks++;
    if (lat !== 3) $display("FAIL half_read_latency: got %0d want 3 (0 = timeout)", lat);
    else passes++;
    checks++;
    if (data_in !== 32'h0000_5A34) $display("FAIL half_read_data: got %h want 00005a34", data_in);
    else passes++;
    checks++;
    if (mem[15'h180] !== 16'h5A34) $display("FAIL byte_write_mem: got %h want 5a34", mem[15'h180]);
    else passes++;
    tick();
    data_read_n = MEM_IDLE;
    tick(); tick();
  endtask

  task automatic test_word_write_wrap();
    data_addr = 28'h000FFFE;
    data_out = 32'h1122_3344;
    data_write_n = MEM_WORD;
    tick();
    @(negedge clk);
    checks++;
    if ({sram_en, sram_we, sram_be, sram_addr, sram_wdata, data_ready} !== {1'b1, 1'b1, 2'b11, 15'h7FFF, 16'h3344, 1'b0})
      $display("FAIL word_write_lo: got en=%b we=%b be=%b addr=%h wdata=%h rdy=%b want 1 1 11 7fff 3344 0",
               sram_en, sram_we, sram_be, sram_addr, sram_wdata, data_ready);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if ({sram_en, sram_we, sram_be, sram_addr, sram_wdata, data_ready} !== {1'b1, 1'b1, 2'b11, 15'h0000, 16'h1122, 1'b1})
      $display("FAIL word_write_hi_wrap: got en=%b we=%b be=%b addr=%h wdata=%h rdy=%b want 1 1 11 0000 1122 1",
               sram_en, sram_we, sram_be, sram_addr, sram_wdata, data_ready);
    else passes++;
    tick();
    data_write_n = MEM_IDLE;
    tick(); tick();
    checks++;
    if ({mem[15'h7FFF], mem[15'h0000]} !== 32'h3344_1122)
      $display("FAIL word_write_mem: got top=%h zero=%h want top=3344 zero=1122", mem[15'h7FFF], mem[15'h0000]);
    else passes++;
  endtask

  task automatic test_reset_mid_read();
    logic bad;
    data_addr = 28'h200;
    data_read_n = MEM_WORD;
    tick();
    tick();
    rst = 1'b1;
    data_read_n = MEM_IDLE;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_ready, instr_fetch_started, instr_fetch_stopped, data_ready, sram_en, sram_we} !== 6'b0)
      $display("FAIL reset_mid_flags: got %b want 000000",
               {instr_ready, instr_fetch_started, instr_fetch_stopped, data_ready, sram_en, sram_we});
    else passes++;
    checks++;
    if (data_in !== 32'h0) $display("FAIL reset_mid_data_in: got %h want 00000000", data_in);
    else passes++;
    checks++;
    if (instr_data_in !== 16'h0) $display("FAIL reset_mid_instr_data: got %h want 0000", instr_data_in);
    else passes++;
    tick();
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (data_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) $display("FAIL reset_discard_ready: got late data_ready=%b want 0", bad);
    else passes++;
    instr_addr = 23'h100;
    instr_fetch_restart = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_fetch_started !== 1'b1) $display("FAIL post_reset_started: got %b want 1", instr_fetch_started);
    else passes++;
    tick();
    instr_fetch_restart = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_ready, instr_data_in} !== {1'b1, 16'hBABE})
      $display("FAIL post_reset_fetch: got ready=%b data=%h want ready=1 data=babe", instr_ready, instr_data_in);
    else passes++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    instr_addr = 23'h0;
    instr_fetch_restart = 1'b0;
    instr_fetch_stall = 1'b0;
    data_addr = 28'h0;
    data_write_n = MEM_IDLE;
    data_read_n = MEM_IDLE;
    data_read_complete = 1'b0;
    data_out = 32'h0;
    data_continue = 1'b0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = 16'h0;

    test_reset();
    test_fetch_stall();
    test_preempt_read();
    test_ignored_region();
    test_byte_write_half_read();
    test_word_write_wrap();
    test_reset_mid_read();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
